// File: rtl/div_issue_stage_if.sv
// Request and stage-chain bus for the divider issue stage.
//   Request side : in_valid / in_ready / in_dividend / in_divisor
//   Chain side   : out_valid / out_ready, stage operands st_*, sideband out_*
// slave  = issue-stage view (accepts requests, drives the chain)
// master = environment view (request source and chain consumer)
interface div_issue_stage_if #(
    parameter int DIVISOR_BITS  = 8,
    parameter int DIVIDEND_BITS = 16
);
    localparam int ADD_BITS = DIVISOR_BITS + DIVIDEND_BITS - 1;
    localparam int SHIFT_W  = ADD_BITS + DIVISOR_BITS + 1;

    logic                     in_valid;
    logic                     in_ready;
    logic [DIVIDEND_BITS-1:0] in_dividend;
    logic [DIVISOR_BITS-1:0]  in_divisor;

    logic                     out_valid;
    logic                     out_ready;
    logic [ADD_BITS-1:0]      st_divisor;
    logic [ADD_BITS-1:0]      st_dividend;
    logic [SHIFT_W-1:0]       st_shiftby;
    logic [DIVIDEND_BITS-1:0] st_quotient_in;
    logic                     out_div_zero;
    logic                     out_q_neg;
    logic                     out_r_neg;

    modport slave (
        input  in_valid, in_dividend, in_divisor, out_ready,
        output in_ready, out_valid, st_divisor, st_dividend, st_shiftby,
               st_quotient_in, out_div_zero, out_q_neg, out_r_neg
    );

    modport master (
        output in_valid, in_dividend, in_divisor, out_ready,
        input  in_ready, out_valid, st_divisor, st_dividend, st_shiftby,
               st_quotient_in, out_div_zero, out_q_neg, out_r_neg
    );
endinterface

// File: rtl/div_issue_stage.sv
// Issue stage of the restoring divider. Accepts divide requests, converts
// signed operands to magnitudes, flags divide-by-zero and presents
// zero-extended stage-width operands plus sign sideband to the first
// division stage. A head + skid register pair lets the chain stall
// without losing requests or throughput.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - div_issue_stage_if.slave (request handshake in, stage chain out)
module div_issue_stage #(
    parameter int DIVISOR_BITS  = 8,
    parameter int DIVIDEND_BITS = 16,
    parameter int SIGNED        = 1
) (
    input  logic               clk,
    input  logic               rst,
    div_issue_stage_if.slave   bus
);
    localparam int ADD_BITS = DIVISOR_BITS + DIVIDEND_BITS - 1;
    localparam int SHIFT_W  = ADD_BITS + DIVISOR_BITS + 1;

    typedef struct packed {
        logic [ADD_BITS-1:0] dividend;
        logic [ADD_BITS-1:0] divisor;
        logic                div_zero;
        logic                q_neg;
        logic                r_neg;
    } entry_t;

    entry_t head, skid, new_e;
    logic   head_vld, skid_vld;
    logic   push, pop;

    logic                     dd_msb, dv_msb, dd_nz, dv_zero;
    logic [DIVIDEND_BITS-1:0] dd_mag;
    logic [DIVISOR_BITS-1:0]  dv_mag;

    // Sign bits only matter for two's-complement operands.
    assign dd_msb  = (SIGNED != 0) && bus.in_dividend[DIVIDEND_BITS-1];
    assign dv_msb  = (SIGNED != 0) && bus.in_divisor[DIVISOR_BITS-1];
    assign dd_nz   = |bus.in_dividend;
    assign dv_zero = ~|bus.in_divisor;

    // Negation in the operand width: the most-negative value maps onto its
    // exact unsigned magnitude (e.g. 0x8000 -> 0x8000).
    assign dd_mag = dd_msb ? (~bus.in_dividend + DIVIDEND_BITS'(1)) : bus.in_dividend;
    assign dv_mag = dv_msb ? (~bus.in_divisor  + DIVISOR_BITS'(1))  : bus.in_divisor;

    always_comb begin
        new_e          = '0;
        new_e.dividend = ADD_BITS'(dd_mag);
        new_e.divisor  = ADD_BITS'(dv_mag);
        new_e.div_zero = dv_zero;
        new_e.r_neg    = dd_msb && dd_nz;
        new_e.q_neg    = !dv_zero && (dd_msb ^ dv_msb) && dd_nz;
    end

    // in_ready depends only on skid state, so out_ready never reaches it
    // combinationally.
    assign bus.in_ready = !skid_vld;
    assign push         = bus.in_valid && !skid_vld;
    assign pop          = head_vld && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            head_vld <= 1'b0;
            skid_vld <= 1'b0;
            head     <= '0;
            skid     <= '0;
        end else if (pop) begin
            if (skid_vld) begin
                // push cannot coincide here: in_ready is low while skid is full
                head     <= skid;
                skid_vld <= 1'b0;
            end else if (push) begin
                head     <= new_e;
            end else begin
                head_vld <= 1'b0;
            end
        end else if (push) begin
            if (!head_vld) begin
                head     <= new_e;
                head_vld <= 1'b1;
            end else begin
                skid     <= new_e;
                skid_vld <= 1'b1;
            end
        end
    end

    assign bus.out_valid      = head_vld;
    assign bus.st_dividend    = head.dividend;
    assign bus.st_divisor     = head.divisor;
    assign bus.out_div_zero   = head.div_zero;
    assign bus.out_q_neg      = head.q_neg;
    assign bus.out_r_neg      = head.r_neg;
    assign bus.st_shiftby     = SHIFT_W'(DIVIDEND_BITS - 1);
    assign bus.st_quotient_in = '0;
endmodule

// File: tb/tb_div_issue_stage.sv
module tb_div_issue_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    div_issue_stage_if #(.DIVISOR_BITS(8), .DIVIDEND_BITS(16)) bus ();

    div_issue_stage #(.DIVISOR_BITS(8), .DIVIDEND_BITS(16), .SIGNED(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // advance one clock; inputs are driven and outputs sampled 1 time unit after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] dd, input logic [7:0] dv);
        bus.in_valid    = v;
        bus.in_dividend = dd;
        bus.in_divisor  = dv;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 16'd0, 8'd0);
        bus.out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        checks++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL reset_handshake: got v/r=%b%b want 01", bus.out_valid, bus.in_ready);
        end
        checks++;
        if (bus.st_dividend !== 23'd0 || bus.st_divisor !== 23'd0 || bus.st_quotient_in !== 16'd0) begin
            errors++;
            $display("FAIL reset_data: got dd=%0d dv=%0d q=%0d want 0 0 0",
                     bus.st_dividend, bus.st_divisor, bus.st_quotient_in);
        end
        checks++;
        if ({bus.out_div_zero, bus.out_q_neg, bus.out_r_neg} !== 3'b000 || bus.st_shiftby !== 32'd15) begin
            errors++;
            $display("FAIL reset_side: got z/q/r=%b%b%b shift=%0d want 000 15",
                     bus.out_div_zero, bus.out_q_neg, bus.out_r_neg, bus.st_shiftby);
        end
    endtask

    task automatic test_basic();
        bus.out_ready = 1'b1;
        drive(1'b1, 16'd100, 8'd7);
        step();
        drive(1'b0, 16'd0, 8'd0);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.st_dividend !== 23'd100 || bus.st_divisor !== 23'd7) begin
            errors++;
            $display("FAIL basic_data: got v=%b dd=%0d dv=%0d want 1 100 7",
                     bus.out_valid, bus.st_dividend, bus.st_divisor);
        end
        checks++;
        if (bus.st_shiftby !== 32'd15 || bus.st_quotient_in !== 16'd0 ||
            {bus.out_div_zero, bus.out_q_neg, bus.out_r_neg} !== 3'b000) begin
            errors++;
            $display("FAIL basic_side: got shift=%0d q=%0d z/q/r=%b%b%b want 15 0 000",
                     bus.st_shiftby, bus.st_quotient_in, bus.out_div_zero, bus.out_q_neg, bus.out_r_neg);
        end
        step();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_drain: got out_valid=%b want 0", bus.out_valid);
        end
    endtask

    task automatic test_signed();
        // dividend, divisor, |dividend|, |divisor|, {div_zero,q_neg,r_neg}
        logic [15:0] t_dd  [6] = '{16'hFF9C, 16'h8000, 16'd55, 16'd0, 16'd100, 16'h8000};
        logic [7:0]  t_dv  [6] = '{8'd7,     8'hFF,    8'd0,   8'hFB, 8'hF9,   8'h80};
        int          e_dd  [6] = '{100,      32768,    55,     0,     100,     32768};
        int          e_dv  [6] = '{7,        1,        0,      5,     7,       128};
        logic [2:0]  e_sb  [6] = '{3'b011,   3'b001,   3'b100, 3'b000, 3'b010, 3'b001};
        bus.out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, t_dd[i], t_dv[i]);
            step();
            drive(1'b0, 16'd0, 8'd0);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.st_dividend !== 23'(e_dd[i]) || bus.st_divisor !== 23'(e_dv[i])) begin
                errors++;
                $display("FAIL signed_mag[%0d]: got v=%b dd=%0d dv=%0d want 1 %0d %0d",
                         i, bus.out_valid, bus.st_dividend, bus.st_divisor, e_dd[i], e_dv[i]);
            end
            checks++;
            if ({bus.out_div_zero, bus.out_q_neg, bus.out_r_neg} !== e_sb[i]) begin
                errors++;
                $display("FAIL signed_side[%0d]: got z/q/r=%b%b%b want %b",
                         i, bus.out_div_zero, bus.out_q_neg, bus.out_r_neg, e_sb[i]);
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        drive(1'b1, 16'd11, 8'd3);   // A
        step();
        checks++;
        if ({bus.out_valid, bus.in_ready} !== 2'b11 || bus.st_dividend !== 23'd11) begin
            errors++;
            $display("FAIL bp_a_head: got v/r=%b%b dd=%0d want 11 11", bus.out_valid, bus.in_ready, bus.st_dividend);
        end
        drive(1'b1, 16'd22, 8'd3);   // B
        step();
        checks++;
        if ({bus.out_valid, bus.in_ready} !== 2'b10 || bus.st_dividend !== 23'd11) begin
            errors++;
            $display("FAIL bp_b_skid: got v/r=%b%b dd=%0d want 10 11", bus.out_valid, bus.in_ready, bus.st_dividend);
        end
        drive(1'b1, 16'd33, 8'd3);   // C held by the source
        step();
        checks++;
        if ({bus.out_valid, bus.in_ready} !== 2'b10 || bus.st_dividend !== 23'd11) begin
            errors++;
            $display("FAIL bp_hold: got v/r=%b%b dd=%0d want 10 11", bus.out_valid, bus.in_ready, bus.st_dividend);
        end
        bus.out_ready = 1'b1;
        step();
        checks++;
        if ({bus.out_valid, bus.in_ready} !== 2'b11 || bus.st_dividend !== 23'd22) begin
            errors++;
            $display("FAIL bp_pop_b: got v/r=%b%b dd=%0d want 11 22", bus.out_valid, bus.in_ready, bus.st_dividend);
        end
        step();
        drive(1'b0, 16'd0, 8'd0);
        checks++;
        if ({bus.out_valid, bus.in_ready} !== 2'b11 || bus.st_dividend !== 23'd33) begin
            errors++;
            $display("FAIL bp_pop_c: got v/r=%b%b dd=%0d want 11 33", bus.out_valid, bus.in_ready, bus.st_dividend);
        end
        step();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: got out_valid=%b want 0", bus.out_valid);
        end
    endtask

    task automatic test_stream();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 16'(200 + i), 8'(i + 1));
            step();
            checks++;
            if ({bus.out_valid, bus.in_ready} !== 2'b11 || bus.st_dividend !== 23'(200 + i) ||
                bus.st_divisor !== 23'(i + 1)) begin
                errors++;
                $display("FAIL stream[%0d]: got v/r=%b%b dd=%0d dv=%0d want 11 %0d %0d",
                         i, bus.out_valid, bus.in_ready, bus.st_dividend, bus.st_divisor, 200 + i, i + 1);
            end
        end
        drive(1'b0, 16'd0, 8'd0);
        step();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stream_drain: got out_valid=%b want 0", bus.out_valid);
        end
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        drive(1'b1, 16'hFF00, 8'hF0);
        step();
        drive(1'b1, 16'd88, 8'd0);
        step();
        drive(1'b0, 16'd0, 8'd0);
        checks++;
        if ({bus.out_valid, bus.in_ready} !== 2'b10) begin
            errors++;
            $display("FAIL rmid_full: got v/r=%b%b want 10", bus.out_valid, bus.in_ready);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if ({bus.out_valid, bus.in_ready} !== 2'b01 || bus.st_dividend !== 23'd0 ||
            {bus.out_div_zero, bus.out_q_neg, bus.out_r_neg} !== 3'b000) begin
            errors++;
            $display("FAIL rmid_clear: got v/r=%b%b dd=%0d z/q/r=%b%b%b want 01 0 000",
                     bus.out_valid, bus.in_ready, bus.st_dividend, bus.out_div_zero, bus.out_q_neg, bus.out_r_neg);
        end
        bus.out_ready = 1'b1;
        drive(1'b1, 16'd9, 8'd3);
        step();
        drive(1'b0, 16'd0, 8'd0);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.st_dividend !== 23'd9 || bus.st_divisor !== 23'd3 ||
            {bus.out_div_zero, bus.out_q_neg, bus.out_r_neg} !== 3'b000) begin
            errors++;
            $display("FAIL rmid_next: got v=%b dd=%0d dv=%0d z/q/r=%b%b%b want 1 9 3 000",
                     bus.out_valid, bus.st_dividend, bus.st_divisor, bus.out_div_zero, bus.out_q_neg, bus.out_r_neg);
        end
        step();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rmid_drain: got out_valid=%b want 0", bus.out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_backpressure();
        test_stream();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/div_issue_stage.md
Name: div_issue_stage

Overview:
- Front-end stage of the restoring divider. Sits directly upstream of the first restoring-division stage in the combinational stage chain.
- Accepts divide requests on a valid/ready handshake and converts signed operands to magnitudes.
- Flags divide-by-zero and presents zero-extended, stage-width operands plus sign/zero sideband to the chain.
- Contains a 2-entry skid buffer, so the chain may stall without losing requests or throughput.

Parameters:
DIVISOR_BITS, 8, divisor operand width
DIVIDEND_BITS, 16, dividend operand width
ADD_BITS, DIVISOR_BITS+DIVIDEND_BITS-1, stage datapath width; derived, never overridden
SIGNED, 1, 1 = two's-complement operands, 0 = unsigned operands

Ports:
clk  input  1  sole clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  request present
in_ready  output  1  block can accept a request this cycle
in_dividend  input  DIVIDEND_BITS  dividend operand
in_divisor  input  DIVISOR_BITS  divisor operand
out_valid  output  1  head entry valid toward stage chain
out_ready  input  1  chain consumer accepts head entry
st_divisor  output  ADD_BITS  divisor magnitude, zero-extended
st_dividend  output  ADD_BITS  dividend magnitude, zero-extended
st_shiftby  output  ADD_BITS+DIVISOR_BITS+1  first-stage shift amount, constant DIVIDEND_BITS-1
st_quotient_in  output  DIVIDEND_BITS  seed quotient, always 0
out_div_zero  output  1  divisor was zero
out_q_neg  output  1  final quotient must be negated downstream
out_r_neg  output  1  final remainder must be negated downstream

Behaviour:
- Handshake: transfer in when in_valid && in_ready; transfer out when out_valid && out_ready. in_ready is registered and equals "skid entry empty".
- Reset: both entries invalid; out_valid=0; in_ready=1. All data/sideband outputs = 0, except st_shiftby, which stays constant.
- Conversion is done at capture, on input operands.
  - SIGNED=1: magnitude = operand MSB ? (~operand+1) : operand, unsigned result in the same width.
  - Most-negative values convert exactly: -32768 -> 32768 (0x8000); -128 -> 128 (0x80).
  - SIGNED=0: magnitude = operand.
  - Zero-extend magnitudes to ADD_BITS.
- Sideband:
  - div_zero = (in_divisor == 0).
  - r_neg = SIGNED && dividend MSB && (dividend != 0).
  - q_neg = SIGNED && !div_zero && (dividend MSB xor divisor MSB) && (dividend != 0).
  - When div_zero=1, st_divisor=0 and the entry still flows normally; downstream applies the divide-by-zero result.
- Storage: head register (drives outputs) and skid register.
  - Accept with head empty, or head popping this cycle with skid empty -> write head.
  - Accept while head valid and not popping -> write skid; in_ready goes 0 next cycle.
  - Pop with skid valid -> skid moves to head, skid cleared, in_ready goes 1 next cycle.
  - Accept and pop in the same cycle with skid empty -> new entry into head, no bubble.
  - Order is strictly FIFO. Entries are never dropped or duplicated.
- Latency: 1 cycle from input accept to out_valid; sustained throughput 1 request/cycle while out_ready=1.
- Head outputs are stable while out_valid && !out_ready.
- in_valid while in_ready=0: ignored, no state change.
- Reset asserted mid-operation: all pending entries are discarded at that edge and the block returns to reset values. No partial outputs follow.
- No combinational path from in_* to out_* or from out_ready to in_ready.

Test Plan:
- SIGNED=1, reset, then dividend 100 / divisor 7, out_ready=1 -> next cycle out_valid=1, st_dividend=100, st_divisor=7, st_shiftby=15, st_quotient_in=0, q_neg=0, r_neg=0, div_zero=0.
- Dividend -100 (0xFF9C) / divisor 7 -> st_dividend=100, st_divisor=7, q_neg=1, r_neg=1. Dividend -32768 / divisor -1 -> st_dividend=32768, st_divisor=1, q_neg=0, r_neg=1.
- Dividend 55 / divisor 0 -> div_zero=1, st_divisor=0, q_neg=0, entry emitted normally. Dividend 0 / divisor -5 -> q_neg=0, r_neg=0.
- Backpressure: out_ready=0, offer A, B, C back-to-back -> A in head, B in skid, in_ready=0 from cycle after B, C held by source. Raise out_ready -> A, B, C emitted in order, one per cycle, no duplicates.
- Streaming: 20 consecutive requests with out_ready=1 -> 20 outputs on consecutive cycles, in_ready never drops.
- Reset with both entries full -> next cycle out_valid=0, in_ready=1; first post-reset request emerges unaffected by pre-reset data.
